led_scan_capture: RTL and testbench
===================================

LED_SCAN_CAPTURE -- requirements
Module: led_scan_capture

Interface
REQ-001 Parameter NUM_COLS, default 16, columns per frame.
REQ-002 Parameter COL_W, default 16, bits per column word.
REQ-003 Parameter ERR_W, default 8, error-counter width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 scan_en  input  1  col_sel/col_data sample qualifier; sampled only when high.
REQ-007 col_sel  input  4  column index from the matrix scan driver.
REQ-008 col_data  input  COL_W  column pixel word paired with col_sel.
REQ-009 clear  input  1  synchronous flush: discard partial frame, zero err_cnt, return to HUNT.
REQ-010 frame  output  NUM_COLS*COL_W  last complete captured frame; column k occupies bits [k*COL_W +: COL_W].
REQ-011 frame_done  output  1  one-cycle pulse when frame updates.
REQ-012 locked  output  1  high while a frame was completed with no error since.
REQ-013 scan_err  output  1  one-cycle pulse on column-sequence violation.
REQ-014 err_cnt  output  ERR_W  saturating count of sequence violations.

Function
REQ-015 States: HUNT, CAPTURE; one state register, 2-bit encoding.
REQ-016 HUNT: sample with col_sel != 0 ignored, no error; sample with col_sel == 0 writes shadow column 0, expected index = 1, next state CAPTURE.
REQ-017 CAPTURE: sample with col_sel == expected writes shadow column col_sel, expected increments.
REQ-018 CAPTURE: sample with col_sel != expected -> scan_err pulses next cycle, err_cnt increments (saturates at all-ones), locked clears, state HUNT, partial shadow discarded (frame unchanged).
REQ-019 Exception to REQ-018: mismatching sample with col_sel == 0 also restarts capture (shadow column 0 written, expected = 1, state CAPTURE) while still counting the error.
REQ-020 Accepted sample with col_sel == NUM_COLS-1: frame <= shadow with column NUM_COLS-1 taken directly from col_data, in the cycle after the sample; frame_done and locked assert in that same cycle; expected wraps to 0; state stays CAPTURE.
REQ-021 Latency: sample of final column to frame/frame_done = 1 cycle; no intermediate pipeline stage.
REQ-022 frame changes only on frame_done; a partial or aborted frame never reaches frame.
REQ-023 scan_en low: no state, shadow, counter or output change; pulses deassert.
REQ-024 clear has priority over a simultaneous sample: sample discarded, state HUNT, err_cnt = 0, locked = 0; frame retains its value.
REQ-025 col_sel values >= NUM_COLS (when NUM_COLS < 16) treated as mismatch in CAPTURE, ignored in HUNT.
REQ-026 Back-to-back samples on every clock (driver at full rate) supported with no dropped column.

Reset
REQ-027 rst_n low: state HUNT, expected 0, shadow 0, frame 0, frame_done 0, locked 0, scan_err 0, err_cnt 0.
REQ-028 Reset mid-frame discards the partial frame; capture restarts at the next col_sel == 0 after rst_n rises.
REQ-029 Reset deassertion need not be synchronised inside the block; system reset synchroniser supplies it.

Structure
REQ-030 Shared package led_matrix_pkg holds NUM_COLS, COL_W, FRAME_W (= NUM_COLS*COL_W) and the capture state encoding, shared with the scan driver.
REQ-031 One sub-module: sat_counter (ERR_W wide, inc/clear, saturating), instanced for err_cnt; all else inline.
REQ-032 Target 120-400 lines RTL; shadow register NUM_COLS*COL_W flops plus frame register.

Verification
REQ-033 Reset then 16 in-order samples, column k data = 16'hA500+k -> 1 cycle after col 15: frame_done=1, frame[k*16+:16]=16'hA500+k, locked=1, err_cnt=0.
REQ-034 Start stream at col_sel=5 -> cols 5..15 ignored, no scan_err; capture starts at next col 0, frame_done after following col 15.
REQ-035 In CAPTURE, sequence 0,1,2,4 -> scan_err pulse, err_cnt=1, locked=0, frame unchanged; 255 more violations -> err_cnt stays 8'hFF.
REQ-036 scan_en toggled 1/0 every cycle across a full frame -> identical frame contents as continuous run; frame_done once.
REQ-037 clear asserted together with col 15 sample -> no frame_done, frame unchanged, err_cnt=0, state HUNT.
REQ-038 rst_n pulsed low at col 8 -> all outputs 0 during reset; next frame_done only after a complete 0..15 sequence.

Source files
------------

// File: rtl/led_matrix_pkg.sv
// Definitions shared between the LED matrix scan driver and the column capture block.
package led_matrix_pkg;
   localparam int NUM_COLS = 16;
   localparam int COL_W    = 16;
   localparam int FRAME_W  = NUM_COLS * COL_W;
   localparam int SEL_W    = 4;

   typedef enum logic [1:0] {
      ST_HUNT    = 2'b00,
      ST_CAPTURE = 2'b01
   } capture_state_e;
endpackage

// File: rtl/led_scan_capture_if.sv
// Column stream in, captured frame and status out.
interface led_scan_capture_if #(
   parameter int NUM_COLS = 16,
   parameter int COL_W    = 16,
   parameter int ERR_W    = 8
);
   import led_matrix_pkg::*;

   logic                      scan_en;
   logic [SEL_W-1:0]          col_sel;
   logic [COL_W-1:0]          col_data;
   logic                      clear;
   logic [NUM_COLS*COL_W-1:0] frame;
   logic                      frame_done;
   logic                      locked;
   logic                      scan_err;
   logic [ERR_W-1:0]          err_cnt;

   modport master (
      output scan_en, col_sel, col_data, clear,
      input  frame, frame_done, locked, scan_err, err_cnt
   );

   modport slave (
      input  scan_en, col_sel, col_data, clear,
      output frame, frame_done, locked, scan_err, err_cnt
   );
endinterface

// File: rtl/led_scan_capture_sat_counter.sv
// Saturating up-counter; clr wins over inc, the count sticks at all-ones.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);
   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && (cnt_q != '1))
         cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;
endmodule

// File: rtl/led_scan_capture.sv
// Reassembles full frames from the matrix column scan and flags out-of-order columns.
// state      | meaning
// ST_HUNT    | waiting for column 0 to start a frame; other columns ignored
// ST_CAPTURE | collecting columns in order; exp_q holds the next column index
module led_scan_capture #(
   parameter int NUM_COLS = led_matrix_pkg::NUM_COLS,
   parameter int COL_W    = led_matrix_pkg::COL_W,
   parameter int ERR_W    = 8
) (
   input logic               clk,
   input logic               rst_n,
   led_scan_capture_if.slave bus
);
   import led_matrix_pkg::*;

   localparam int               FRAME_BITS = NUM_COLS * COL_W;
   localparam logic [SEL_W-1:0] LAST_COL   = SEL_W'(NUM_COLS - 1);

   capture_state_e          state_q, state_d;
   logic [SEL_W-1:0]        exp_q, exp_d;
   logic [FRAME_BITS-1:0]   shadow_q, shadow_d;
   logic [FRAME_BITS-1:0]   frame_q, frame_d;
   logic                    frame_done_q, frame_done_d;
   logic                    locked_q, locked_d;
   logic                    scan_err_q, scan_err_d;
   logic                    err_inc, err_clr;

   always_comb begin
      state_d      = state_q;
      exp_d        = exp_q;
      shadow_d     = shadow_q;
      frame_d      = frame_q;
      frame_done_d = 1'b0;
      locked_d     = locked_q;
      scan_err_d   = 1'b0;
      err_inc      = 1'b0;
      err_clr      = 1'b0;

      if (bus.clear) begin
         state_d  = ST_HUNT;
         exp_d    = '0;
         locked_d = 1'b0;
         err_clr  = 1'b1;
      end else if (bus.scan_en) begin
         case (state_q)
            ST_CAPTURE: begin
               if (bus.col_sel == exp_q) begin
                  shadow_d[int'(bus.col_sel)*COL_W +: COL_W] = bus.col_data;
                  if (bus.col_sel == LAST_COL) begin
                     // last column goes straight from col_data into frame via shadow_d
                     frame_d      = shadow_d;
                     frame_done_d = 1'b1;
                     locked_d     = 1'b1;
                     exp_d        = '0;
                  end else begin
                     exp_d = exp_q + SEL_W'(1);
                  end
               end else begin
                  scan_err_d = 1'b1;
                  err_inc    = 1'b1;
                  locked_d   = 1'b0;
                  // an unexpected column 0 is still a valid frame start
                  if (bus.col_sel == '0) begin
                     shadow_d[COL_W-1:0] = bus.col_data;
                     exp_d               = SEL_W'(1);
                     state_d             = ST_CAPTURE;
                  end else begin
                     exp_d   = '0;
                     state_d = ST_HUNT;
                  end
               end
            end
            default: begin
               if (bus.col_sel == '0) begin
                  shadow_d[COL_W-1:0] = bus.col_data;
                  exp_d               = SEL_W'(1);
                  state_d             = ST_CAPTURE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_HUNT;
         exp_q        <= '0;
         shadow_q     <= '0;
         frame_q      <= '0;
         frame_done_q <= 1'b0;
         locked_q     <= 1'b0;
         scan_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         exp_q        <= exp_d;
         shadow_q     <= shadow_d;
         frame_q      <= frame_d;
         frame_done_q <= frame_done_d;
         locked_q     <= locked_d;
         scan_err_q   <= scan_err_d;
      end
   end

   sat_counter #(.W(ERR_W)) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (err_inc),
      .clr   (err_clr),
      .cnt   (bus.err_cnt)
   );

   assign bus.frame      = frame_q;
   assign bus.frame_done = frame_done_q;
   assign bus.locked     = locked_q;
   assign bus.scan_err   = scan_err_q;
endmodule

// File: tb/tb_led_scan_capture.sv
// Directed bench for led_scan_capture with hand-derived expected frames and counters.
module tb_led_scan_capture;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_fail = 0;
   int   done_seen = 0;
   int   err_seen = 0;

   led_scan_capture_if #(.NUM_COLS(16), .COL_W(16), .ERR_W(8)) bus ();

   led_scan_capture #(.NUM_COLS(16), .COL_W(16), .ERR_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [255:0] exp_frame(input logic [15:0] base);
      logic [255:0] f;
      f = '0;
      for (int k = 0; k < 16; k++) f[k*16 +: 16] = base + 16'(k);
      return f;
   endfunction

   // all helpers start and end 1 time unit after a rising edge
   task automatic step(input logic en, input logic [3:0] sel, input logic [15:0] data, input logic clr);
      bus.scan_en  = en;
      bus.col_sel  = sel;
      bus.col_data = data;
      bus.clear    = clr;
      @(posedge clk);
      #1;
      done_seen += int'(bus.frame_done);
      err_seen  += int'(bus.scan_err);
   endtask

   task automatic send_cols(input int first, input int last, input logic [15:0] base);
      for (int k = first; k <= last; k++) step(1'b1, 4'(k), base + 16'(k), 1'b0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.scan_en = 1'b0; bus.col_sel = '0; bus.col_data = '0; bus.clear = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (bus.frame !== 256'd0) begin n_fail++; $display("FAIL reset_frame got %h want 0", bus.frame); end
      n_cmp++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.frame_done); end
      n_cmp++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got %b want 0", bus.locked); end
      n_cmp++; if (bus.scan_err !== 1'b0) begin n_fail++; $display("FAIL reset_scan_err got %b want 0", bus.scan_err); end
      n_cmp++; if (bus.err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt got %h want 00", bus.err_cnt); end
      rst_n = 1'b1;
      step(1'b0, 4'd0, 16'd0, 1'b0);
   endtask

   task automatic test_basic_frame();
      done_seen = 0;
      send_cols(0, 14, 16'hA500);
      n_cmp++; if (done_seen !== 0) begin n_fail++; $display("FAIL basic_early_done got %0d want 0", done_seen); end
      send_cols(15, 15, 16'hA500);
      n_cmp++; if (bus.frame_done !== 1'b1) begin n_fail++; $display("FAIL basic_done got %b want 1", bus.frame_done); end
      n_cmp++; if (bus.frame !== exp_frame(16'hA500)) begin n_fail++; $display("FAIL basic_frame got %h want %h", bus.frame, exp_frame(16'hA500)); end
      n_cmp++; if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL basic_locked got %b want 1", bus.locked); end
      n_cmp++; if (bus.err_cnt !== 8'd0) begin n_fail++; $display("FAIL basic_err_cnt got %h want 00", bus.err_cnt); end
      step(1'b0, 4'd3, 16'hFFFF, 1'b0);
      n_cmp++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b want 0", bus.frame_done); end
   endtask

   task automatic test_hunt_start();
      step(1'b0, 4'd0, 16'd0, 1'b1);
      done_seen = 0; err_seen = 0;
      send_cols(5, 15, 16'hB500);
      n_cmp++; if (err_seen !== 0) begin n_fail++; $display("FAIL hunt_no_err got %0d want 0", err_seen); end
      n_cmp++; if (done_seen !== 0) begin n_fail++; $display("FAIL hunt_no_done got %0d want 0", done_seen); end
      n_cmp++; if (bus.frame !== exp_frame(16'hA500)) begin n_fail++; $display("FAIL hunt_frame_kept got %h want %h", bus.frame, exp_frame(16'hA500)); end
      send_cols(0, 15, 16'hB600);
      n_cmp++; if (done_seen !== 1 || bus.frame_done !== 1'b1) begin n_fail++; $display("FAIL hunt_done got %0d/%b want 1/1", done_seen, bus.frame_done); end
      n_cmp++; if (bus.frame !== exp_frame(16'hB600)) begin n_fail++; $display("FAIL hunt_frame got %h want %h", bus.frame, exp_frame(16'hB600)); end
   endtask

   task automatic test_seq_error();
      send_cols(0, 2, 16'hC000);
      step(1'b1, 4'd4, 16'hC004, 1'b0);
      n_cmp++; if (bus.scan_err !== 1'b1) begin n_fail++; $display("FAIL seq_scan_err got %b want 1", bus.scan_err); end
      n_cmp++; if (bus.err_cnt !== 8'd1) begin n_fail++; $display("FAIL seq_err_cnt got %h want 01", bus.err_cnt); end
      n_cmp++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL seq_locked got %b want 0", bus.locked); end
      n_cmp++; if (bus.frame !== exp_frame(16'hB600)) begin n_fail++; $display("FAIL seq_frame_kept got %h want %h", bus.frame, exp_frame(16'hB600)); end
      step(1'b0, 4'd0, 16'd0, 1'b0);
      n_cmp++; if (bus.scan_err !== 1'b0) begin n_fail++; $display("FAIL seq_err_pulse got %b want 0", bus.scan_err); end
      // from HUNT col 0 is accepted; repeated col 0 then mismatches (expected 1) and restarts
      step(1'b1, 4'd0, 16'hC100, 1'b0);
      n_cmp++; if (bus.err_cnt !== 8'd1 || bus.scan_err !== 1'b0) begin n_fail++; $display("FAIL seq_hunt_restart got %h/%b want 01/0", bus.err_cnt, bus.scan_err); end
      for (int i = 1; i <= 255; i++) begin
         step(1'b1, 4'd0, 16'hC100, 1'b0);
         if (i == 253) begin
            n_cmp++; if (bus.err_cnt !== 8'hFE) begin n_fail++; $display("FAIL seq_err_cnt_fe got %h want fe", bus.err_cnt); end
         end
      end
      n_cmp++; if (bus.err_cnt !== 8'hFF) begin n_fail++; $display("FAIL seq_err_sat got %h want ff", bus.err_cnt); end
      n_cmp++; if (bus.scan_err !== 1'b1) begin n_fail++; $display("FAIL seq_sat_pulse got %b want 1", bus.scan_err); end
   endtask

   task automatic test_clear_last();
      done_seen = 0;
      send_cols(1, 14, 16'hC700);
      step(1'b1, 4'd15, 16'hC70F, 1'b1);
      n_cmp++; if (done_seen !== 0) begin n_fail++; $display("FAIL clr_no_done got %0d want 0", done_seen); end
      n_cmp++; if (bus.frame !== exp_frame(16'hB600)) begin n_fail++; $display("FAIL clr_frame_kept got %h want %h", bus.frame, exp_frame(16'hB600)); end
      n_cmp++; if (bus.err_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_err_cnt got %h want 00", bus.err_cnt); end
      n_cmp++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL clr_locked got %b want 0", bus.locked); end
      step(1'b1, 4'd5, 16'hC705, 1'b0);
      n_cmp++; if (bus.scan_err !== 1'b0 || bus.err_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_in_hunt got %b/%h want 0/00", bus.scan_err, bus.err_cnt); end
   endtask

   task automatic test_throttled();
      done_seen = 0; err_seen = 0;
      for (int k = 0; k < 16; k++) begin
         step(1'b1, 4'(k), 16'hD000 + 16'(k), 1'b0);
         step(1'b0, 4'(k + 3), 16'hFFFF, 1'b0);
      end
      n_cmp++; if (done_seen !== 1 || err_seen !== 0) begin n_fail++; $display("FAIL thr_done got %0d/%0d want 1/0", done_seen, err_seen); end
      n_cmp++; if (bus.frame !== exp_frame(16'hD000)) begin n_fail++; $display("FAIL thr_frame got %h want %h", bus.frame, exp_frame(16'hD000)); end
      n_cmp++; if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL thr_locked got %b want 1", bus.locked); end
   endtask

   task automatic test_reset_mid();
      send_cols(0, 8, 16'hE000);
      rst_n = 1'b0;
      #2;
      n_cmp++; if (bus.frame !== 256'd0 || bus.locked !== 1'b0 || bus.frame_done !== 1'b0 || bus.scan_err !== 1'b0 || bus.err_cnt !== 8'd0)
         begin n_fail++; $display("FAIL rst_mid_outputs got %h/%b/%b/%b/%h want 0/0/0/0/00", bus.frame, bus.locked, bus.frame_done, bus.scan_err, bus.err_cnt); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      done_seen = 0; err_seen = 0;
      send_cols(9, 15, 16'hE000);
      n_cmp++; if (done_seen !== 0 || bus.frame !== 256'd0) begin n_fail++; $display("FAIL rst_mid_partial got %0d/%h want 0/0", done_seen, bus.frame); end
      send_cols(0, 15, 16'hF000);
      n_cmp++; if (done_seen !== 1 || bus.frame !== exp_frame(16'hF000)) begin n_fail++; $display("FAIL rst_mid_frame got %0d/%h want 1/%h", done_seen, bus.frame, exp_frame(16'hF000)); end
   endtask

   task automatic test_back_to_back();
      done_seen = 0; err_seen = 0;
      send_cols(0, 15, 16'h1100);
      n_cmp++; if (bus.frame_done !== 1'b1 || bus.frame !== exp_frame(16'h1100)) begin n_fail++; $display("FAIL b2b_first got %b/%h want 1/%h", bus.frame_done, bus.frame, exp_frame(16'h1100)); end
      send_cols(0, 15, 16'h2200);
      n_cmp++; if (done_seen !== 2 || err_seen !== 0) begin n_fail++; $display("FAIL b2b_count got %0d/%0d want 2/0", done_seen, err_seen); end
      n_cmp++; if (bus.frame !== exp_frame(16'h2200)) begin n_fail++; $display("FAIL b2b_frame got %h want %h", bus.frame, exp_frame(16'h2200)); end
      step(1'b0, 4'd0, 16'd0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_hunt_start();
      test_seq_error();
      test_clear_last();
      test_throttled();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
